// File: rtl/gray_counter_param_if.sv
// Control and count bus of the parametrised gray counter.
interface gray_counter_param_if #(
    parameter int unsigned WIDTH = 3
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             Clr;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] BinOut;
    logic             Overflow;
    logic             Wrap;

    modport master (
        output En, Up, Load, LoadVal, Clr,
        input  Output, BinOut, Overflow, Wrap
    );

    modport slave (
        input  En, Up, Load, LoadVal, Clr,
        output Output, BinOut, Overflow, Wrap
    );
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised up/down gray counter with load, clear, wrap/saturate mode and
// sticky or pulsed overflow. The gray output is registered from the next binary count.
module gray_counter_param #(
    parameter int unsigned WIDTH      = 3,
    parameter bit          SATURATE   = 1'b0,
    parameter bit          STICKY_OVF = 1'b1
) (
    input logic                 Clk,
    input logic                 Reset_n,
    gray_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_nx;
    logic [WIDTH-1:0] gray_q;
    logic             ovf_q;
    logic             ovf_nx;
    logic             wrap_q;
    logic             wrap_nx;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-state: Clr beats Load beats En; boundary steps raise Overflow.
    always_comb begin
        bin_nx  = bin_q;
        ovf_nx  = STICKY_OVF ? ovf_q : 1'b0;
        wrap_nx = 1'b0;
        if (bus.Clr) begin
            bin_nx = '0;
            ovf_nx = 1'b0;
        end else if (bus.Load) begin
            bin_nx = gray2bin(bus.LoadVal);
        end else if (bus.En) begin
            if (bus.Up) begin
                if (bin_q == MAX_VAL) begin
                    ovf_nx = 1'b1;
                    if (!SATURATE) begin
                        bin_nx  = '0;
                        wrap_nx = 1'b1;
                    end
                end else begin
                    bin_nx = bin_q + WIDTH'(1);
                end
            end else begin
                if (bin_q == '0) begin
                    ovf_nx = 1'b1;
                    if (!SATURATE) begin
                        bin_nx  = MAX_VAL;
                        wrap_nx = 1'b1;
                    end
                end else begin
                    bin_nx = bin_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            ovf_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nx;
            gray_q <= bin_nx ^ (bin_nx >> 1);
            ovf_q  <= ovf_nx;
            wrap_q <= wrap_nx;
        end
    end

    assign bus.Output   = gray_q;
    assign bus.BinOut   = bin_q;
    assign bus.Overflow = ovf_q;
    assign bus.Wrap     = wrap_q;
endmodule

// File: doc/gray_counter_param.md
# gray_counter_param

Parametrised gray-code counter, the successor to the fixed 3-bit `gray` block. It adds configurable width, up/down counting, synchronous load of a gray-coded value, a synchronous clear, and a wrap or saturate mode. It also provides a binary output and a sticky or pulsed overflow flag. It sits wherever a glitch-free multi-bit count must cross logic or clock boundaries, and is driven by the same Clk/En style of control as the existing counter.

## Interface
- WIDTH, 3, counter width in bits; legal range 2..16.
- SATURATE, 0, boundary behaviour: 0 = wrap around, 1 = hold at the end value.
- STICKY_OVF, 1, Overflow behaviour: 1 = held until cleared, 0 = one-cycle pulse.

- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- En  input  1  count enable; one step per enabled edge.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous load of LoadVal.
- LoadVal  input  WIDTH  gray-coded load value.
- Clr  input  1  synchronous clear of the count and of Overflow.
- Output  output  WIDTH  registered gray-coded count.
- BinOut  output  WIDTH  registered binary count, consistent with Output.
- Overflow  output  1  boundary-crossing flag; covers both overflow and underflow.
- Wrap  output  1  one-cycle pulse on an actual wrap-around.

## Operation
- State: binary count register `bin`. Output is a separate register loaded with the gray code of the next `bin` (next ^ next>>1), so it is glitch-free. BinOut equals `bin`.
- Reset (Reset_n = 0): immediately, without waiting for a clock edge, Output = 0, BinOut = 0, Overflow = 0, Wrap = 0.
- Per-edge priority: Clr > Load > En. If none is asserted, the count holds.
- Clr: `bin` becomes 0 and Overflow becomes 0. Wrap = 0.
- Load: `bin` becomes the gray-to-binary conversion of LoadVal (b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]).
  - Overflow is left unchanged (sticky mode) or 0 (pulse mode). Wrap = 0.
- En, Up = 1:
  - If `bin` is below 2^WIDTH-1, `bin` increments.
  - At 2^WIDTH-1 with SATURATE = 0: `bin` becomes 0, Wrap = 1, Overflow = 1.
  - At 2^WIDTH-1 with SATURATE = 1: `bin` holds, Wrap = 0, Overflow = 1.
- En, Up = 0:
  - If `bin` is above 0, `bin` decrements.
  - At 0 with SATURATE = 0: `bin` becomes 2^WIDTH-1, Wrap = 1, Overflow = 1.
  - At 0 with SATURATE = 1: `bin` holds, Wrap = 0, Overflow = 1.
- Sticky mode: once set, Overflow stays 1 until Clr or reset.
- Pulse mode: Overflow is 1 only in the cycle following the boundary event.
- Wrap is always a one-cycle pulse, regardless of STICKY_OVF.
- All arithmetic is modulo 2^WIDTH.
- Up may change between edges. A direction change needs no dead cycle.
- Output changes by exactly one bit per enabled step, except on Load or Clr.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on all outputs after edge N.
- Inputs have no combinational path to any output.
- Reset assertion takes effect asynchronously. Deassertion is taken synchronously: the first count can occur on the first rising edge after Reset_n rises.
- Reset asserted mid-count aborts the count immediately. No pending Wrap or Overflow survives reset.
- Load together with En: Load wins, and the loaded value is not also stepped.
- Clr together with a boundary event: Overflow = 0 and Wrap = 0; Clr wins.
- WIDTH = 2 must behave identically to the general case: sequence 00, 01, 11, 10.

## Test plan
- Default parameters; reset, then En = 1, Up = 1 for 9 cycles.
  - Output must be 001, 011, 010, 110, 111, 101, 100, 000, 001.
  - Wrap = 1 only in the cycle Output = 000; Overflow = 1 from that cycle on.
- Default parameters, Up = 0, starting from reset.
  - First step gives Output = 100, BinOut = 7, Wrap = 1, Overflow = 1.
  - Next step gives Output = 101.
- SATURATE = 1, WIDTH = 4; Load LoadVal = 1000 (binary 15), then En = 1, Up = 1 for 3 cycles.
  - Output stays 1000 and BinOut stays 15.
  - Overflow = 1 and Wrap stays 0.
- STICKY_OVF = 0, default width.
  - Count up through a wrap: Overflow is high for exactly one cycle.
  - Then Clr together with En: Output = 000 and Overflow = 0.
- Load LoadVal = 110 together with En = 1: Output = 110 and BinOut = 4 (no step applied).
  - The next enabled up step gives Output = 111.
- Pull Reset_n low between clock edges mid-count: all outputs read 0 before the next edge.
  - After release, the first enabled edge gives Output = 001.
